// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment receive path.
// Glyph constants are seg_n values written {g,f,e,d,c,b,a}, active-low.
// The alternate glyphs are used only when SEG7_READER_ALT_GLYPH_EN is defined.
// Shadow-state encoding: 5 bits, bit4 = blank, bits[3:0] = nibble.
package seg7_pkg;

    localparam logic [6:0] Glyph0 = 7'h40;
    localparam logic [6:0] Glyph1 = 7'h79;
    localparam logic [6:0] Glyph2 = 7'h24;
    localparam logic [6:0] Glyph3 = 7'h30;
    localparam logic [6:0] Glyph4 = 7'h19;
    localparam logic [6:0] Glyph5 = 7'h12;
    localparam logic [6:0] Glyph6 = 7'h02;
    localparam logic [6:0] Glyph7 = 7'h78;
    localparam logic [6:0] Glyph8 = 7'h00;
    localparam logic [6:0] Glyph9 = 7'h10;
    localparam logic [6:0] GlyphA = 7'h08;
    localparam logic [6:0] GlyphB = 7'h03;
    localparam logic [6:0] GlyphC = 7'h46;
    localparam logic [6:0] GlyphD = 7'h21;
    localparam logic [6:0] GlyphE = 7'h06;
    localparam logic [6:0] GlyphF = 7'h0E;

    localparam logic [6:0] GlyphBlank = 7'h7F;
    localparam logic [6:0] GlyphAlt7  = 7'h58;  // 7 with segment f lit
    localparam logic [6:0] GlyphAlt9  = 7'h18;  // 9 with segment d unlit

    localparam int unsigned DigitIdxW = 3;

    localparam logic [4:0] ShadowBlank = 5'h10;

    typedef enum logic {StTrack, StLocked} state_e;

    // Index of the set bit in a one-hot select (0 if none).
    function automatic logic [DigitIdxW-1:0] onehot_idx(input logic [7:0] sel);
        logic [DigitIdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) idx = DigitIdxW'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] sel);
        return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-low segment pattern to nibble.
// Ports:
//   seg_n  - segment pattern {g..a}, active-low
//   nibble - decoded hex value (0 when blank or err)
//   blank  - pattern is all segments off
//   err    - pattern is not a legal glyph
// Macro SEG7_READER_ALT_GLYPH_EN adds the alternate 7 and 9 glyphs.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg_n)
            Glyph0:     nibble = 4'h0;
            Glyph1:     nibble = 4'h1;
            Glyph2:     nibble = 4'h2;
            Glyph3:     nibble = 4'h3;
            Glyph4:     nibble = 4'h4;
            Glyph5:     nibble = 4'h5;
            Glyph6:     nibble = 4'h6;
            Glyph7:     nibble = 4'h7;
            Glyph8:     nibble = 4'h8;
            Glyph9:     nibble = 4'h9;
            GlyphA:     nibble = 4'hA;
            GlyphB:     nibble = 4'hB;
            GlyphC:     nibble = 4'hC;
            GlyphD:     nibble = 4'hD;
            GlyphE:     nibble = 4'hE;
            GlyphF:     nibble = 4'hF;
            GlyphBlank: blank  = 1'b1;
`ifdef SEG7_READER_ALT_GLYPH_EN
            GlyphAlt7:  nibble = 4'h7;
            GlyphAlt9:  nibble = 4'h9;
`endif
            default:    err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment bus reader: debounces the multiplexed active-low bus, decodes
// each stable pattern, keeps a shadow nibble per digit and reports changes
// through a one-entry valid/ready buffer.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   seg_n[6:0]            - segment bus, active-low, bit0=a .. bit6=g
//   dig_sel[DIGITS-1:0]   - one-hot digit select
//   out_valid/out_ready   - event handshake
//   out_digit/out_nibble/out_blank/out_err - event payload
//   overflow              - sticky, an event was dropped
//   shadow[4*DIGITS-1:0]  - current nibble per digit (0 for blank)
// Macro SEG7_READER_ALT_GLYPH_EN (via seg7_glyph_decode) accepts alternate glyphs.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DigitIdxW-1:0]  out_digit,
    output logic [3:0]            out_nibble,
    output logic                  out_blank,
    output logic                  out_err,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   shadow
);

    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    logic [6:0]           seg_q;
    logic [DIGITS-1:0]    sel_q;
    logic [7:0]           cnt_q, cnt_d;
    state_e               state_q, state_d;
    logic [4:0]           shadow_q [DIGITS];

    logic                 valid_q, blank_q, err_q, ovf_q;
    logic [DigitIdxW-1:0] digit_q;
    logic [3:0]           nibble_q;

    logic [7:0]           sel_in_ext, sel_q_ext;
    logic                 in_changed, sel_in_ok;
    logic                 commit, push, pop, upd_shadow;
    logic [DigitIdxW-1:0] sel_idx;
    logic [3:0]           dec_nibble;
    logic                 dec_blank, dec_err;
    logic [4:0]           res_state, cur_state;

    always_comb begin
        sel_in_ext = '0;
        sel_in_ext[DIGITS-1:0] = dig_sel;
        sel_q_ext = '0;
        sel_q_ext[DIGITS-1:0] = sel_q;
    end

    assign in_changed = (seg_n != seg_q) || (dig_sel != sel_q);
    assign sel_in_ok  = is_onehot(sel_in_ext);
    assign sel_idx    = onehot_idx(sel_q_ext);

    // Stability counter: a bad select holds it at 0 so that run never commits.
    always_comb begin
        cnt_d = cnt_q;
        if (!sel_in_ok) begin
            cnt_d = 8'd0;
        end else if (in_changed) begin
            cnt_d = 8'd1;
        end else if (cnt_q < StableCnt) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= GlyphBlank;
            sel_q <= '0;
            cnt_q <= 8'd0;
        end else begin
            seg_q <= seg_n;
            sel_q <= dig_sel;
            cnt_q <= cnt_d;
        end
    end

    seg7_glyph_decode u_decode (
        .seg_n  (seg_q),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StTrack;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit fires once per stable run: the LOCKED state blocks repeats.
    always_comb begin
        state_d    = state_q;
        commit     = (state_q == StTrack) && (cnt_q == StableCnt);
        res_state  = dec_blank ? ShadowBlank : {1'b0, dec_nibble};
        cur_state  = ShadowBlank;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel_idx == DigitIdxW'(i)) cur_state = shadow_q[i];
        end
        upd_shadow = commit && !dec_err && (res_state != cur_state);
        push       = upd_shadow || (commit && dec_err);
        if (!sel_in_ok || in_changed) begin
            state_d = StTrack;
        end else if (commit) begin
            state_d = StLocked;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DIGITS; i++) shadow_q[i] <= ShadowBlank;
        end else if (upd_shadow) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (sel_idx == DigitIdxW'(i)) shadow_q[i] <= res_state;
            end
        end
    end

    assign pop = valid_q && out_ready;

    // One-entry event buffer; a push with a same-cycle pop replaces the entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            digit_q  <= '0;
            nibble_q <= 4'h0;
            blank_q  <= 1'b0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (push) begin
            if (!valid_q || pop) begin
                valid_q  <= 1'b1;
                digit_q  <= sel_idx;
                nibble_q <= dec_nibble;
                blank_q  <= dec_blank;
                err_q    <= dec_err;
            end else begin
                ovf_q    <= 1'b1;
            end
        end else if (pop) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid  = valid_q;
    assign out_digit  = digit_q;
    assign out_nibble = nibble_q;
    assign out_blank  = blank_q;
    assign out_err    = err_q;
    assign overflow   = ovf_q;

    always_comb begin
        shadow = '0;
        for (int i = 0; i < DIGITS; i++) begin
            shadow[4*i +: 4] = shadow_q[i][3:0];
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader (DIGITS=4, STABLE_CYCLES=4): directed scenarios plus
// randomized bus traffic checked cycle by cycle against a behavioural model.
module tb_seg7_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  dig_sel = 4'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_digit;
    logic [3:0]  out_nibble;
    logic        out_blank;
    logic        out_err;
    logic        overflow;
    logic [15:0] shadow;

    seg7_reader #(
        .DIGITS        (4),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_n      (seg_n),
        .dig_sel    (dig_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_nibble (out_nibble),
        .out_blank  (out_blank),
        .out_err    (out_err),
        .overflow   (overflow),
        .shadow     (shadow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference state: digit values (-1 = blank), one buffered event, run tracking.
    int         m_shadow [4];
    logic       m_valid, m_blank, m_err, m_ovf;
    logic [2:0] m_digit;
    logic [3:0] m_nib;
    int         m_run;
    logic [6:0] m_last_seg;
    logic [3:0] m_last_sel;
    logic       m_pend;

    bit         rec_en = 1'b0;
    logic [5:0] ev_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void ref_decode(input logic [6:0] s, output int val,
                                       output logic bl, output logic er);
        val = 0;
        bl  = 1'b0;
        er  = 1'b1;
        if (s == 7'h7F) begin bl = 1'b1; er = 1'b0; end
        for (int i = 0; i < 16; i++) begin
            if (glyph_tab[i] == s) begin val = i; er = 1'b0; end
        end
`ifdef SEG7_READER_ALT_GLYPH_EN
        if (s == 7'h58) begin val = 7; er = 1'b0; end
        if (s == 7'h18) begin val = 9; er = 1'b0; end
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = -1;
        m_valid = 0; m_blank = 0; m_err = 0; m_ovf = 0; m_digit = 0; m_nib = 0;
        m_run = 0; m_last_seg = 7'h7F; m_last_sel = 4'h0; m_pend = 0;
    endfunction

    // A pattern seen at STABLE consecutive edges with a one-hot select
    // commits on the following edge.
    function automatic void model_edge(input logic [6:0] s, input logic [3:0] d, input logic r);
        logic pop, push, bl, er;
        int   val, idx, st;
        pop  = m_valid && r;
        push = 0;
        if (m_pend) begin
            ref_decode(m_last_seg, val, bl, er);
            idx = 0;
            for (int i = 0; i < 4; i++) if (m_last_sel[i]) idx = i;
            st = bl ? -1 : val;
            if (er) push = 1;
            else if (st != m_shadow[idx]) begin m_shadow[idx] = st; push = 1; end
            if (push) begin
                if (!m_valid || pop) begin
                    m_valid = 1; m_digit = 3'(idx); m_blank = bl; m_err = er;
                    m_nib = (bl || er) ? 4'h0 : 4'(val);
                end else begin
                    m_ovf = 1;
                end
            end
        end
        if (!push && pop) m_valid = 0;
        if (s == m_last_seg && d == m_last_sel) m_run++;
        else begin m_run = 1; m_last_seg = s; m_last_sel = d; end
        m_pend = (m_run == STABLE) && $onehot(d);
    endfunction

    function automatic logic [15:0] exp_shadow();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = (m_shadow[i] < 0) ? 4'h0 : 4'(m_shadow[i]);
        return v;
    endfunction

    task automatic compare_model();
        check("valid", 32'(out_valid), 32'(m_valid));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("shadow", 32'(shadow), 32'(exp_shadow()));
        if (m_valid) begin
            check("digit", 32'(out_digit), 32'(m_digit));
            check("nibble", 32'(out_nibble), 32'(m_nib));
            check("blank", 32'(out_blank), 32'(m_blank));
            check("err", 32'(out_err), 32'(m_err));
        end
    endtask

    task automatic cycle(input logic [6:0] s, input logic [3:0] d, input logic r);
        seg_n = s; dig_sel = d; out_ready = r;
        @(posedge clk);
        model_edge(s, d, r);
        #1;
        compare_model();
        if (rec_en && out_valid) ev_q.push_back({out_blank, out_err, out_nibble});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_outs", 32'({out_digit, out_nibble, out_blank, out_err}), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_shadow", 32'(shadow), 0);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] s;
        logic [3:0] d;
        int         k;

        model_reset();
        do_reset();

        // Latency: 12 on digit 0 appears after edge STABLE+1.
        repeat (STABLE) cycle(7'h12, 4'b0001, 1'b0);
        check("lat_not_early", 32'(out_valid), 0);
        cycle(7'h12, 4'b0001, 1'b0);
        check("lat_valid", 32'(out_valid), 1);
        check("lat_nibble", 32'(out_nibble), 5);
        check("lat_digit", 32'(out_digit), 0);
        check("lat_shadow", 32'(shadow[3:0]), 5);

        // Too-short runs produce nothing.
        do_reset();
        rec_en = 1; ev_q.delete();
        repeat (3) cycle(7'h12, 4'b0001, 1'b1);
        repeat (3) cycle(7'h30, 4'b0001, 1'b1);
        repeat (4) cycle(7'h7F, 4'b0000, 1'b1);
        rec_en = 0;
        check("short_events", ev_q.size(), 0);
        check("short_shadow", 32'(shadow), 0);

        // Long hold, blank, value again: exactly three events.
        do_reset();
        rec_en = 1; ev_q.delete();
        repeat (20) cycle(7'h12, 4'b0001, 1'b1);
        repeat (6) cycle(7'h7F, 4'b0001, 1'b1);
        repeat (6) cycle(7'h12, 4'b0001, 1'b1);
        rec_en = 0;
        check("seq_count", ev_q.size(), 3);
        if (ev_q.size() == 3) begin
            check("seq_ev0", 32'(ev_q[0]), 32'h05);
            check("seq_ev1", 32'(ev_q[1]), 32'h20);
            check("seq_ev2", 32'(ev_q[2]), 32'h05);
        end

        // Alternate glyph 58 on digit 2.
        do_reset();
        repeat (STABLE + 1) cycle(7'h58, 4'b0100, 1'b0);
        check("alt_valid", 32'(out_valid), 1);
        check("alt_digit", 32'(out_digit), 2);
`ifdef SEG7_READER_ALT_GLYPH_EN
        check("alt_err", 32'(out_err), 0);
        check("alt_nibble", 32'(out_nibble), 7);
        check("alt_shadow", 32'(shadow[11:8]), 7);
`else
        check("alt_err", 32'(out_err), 1);
        check("alt_nibble", 32'(out_nibble), 0);
        check("alt_shadow", 32'(shadow[11:8]), 0);
`endif

        // Overflow: second event dropped while first is held.
        do_reset();
        repeat (STABLE + 1) cycle(7'h12, 4'b0001, 1'b0);
        repeat (STABLE + 1) cycle(7'h30, 4'b0010, 1'b0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_held_digit", 32'(out_digit), 0);
        check("ovf_held_nibble", 32'(out_nibble), 5);
        check("ovf_shadow1", 32'(shadow[7:4]), 3);
        cycle(7'h30, 4'b0010, 1'b1);
        check("ovf_popped", 32'(out_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);

        // Non-one-hot select never commits.
        do_reset();
        rec_en = 1; ev_q.delete();
        repeat (10) cycle(7'h12, 4'b0011, 1'b1);
        rec_en = 0;
        check("multisel_events", ev_q.size(), 0);
        check("multisel_shadow", 32'(shadow), 0);

        // Reset part way through a run.
        do_reset();
        repeat (3) cycle(7'h12, 4'b0001, 1'b1);
        do_reset();
        rec_en = 1; ev_q.delete();
        repeat (6) cycle(7'h7F, 4'b0000, 1'b1);
        rec_en = 0;
        check("midrst_events", ev_q.size(), 0);

        // Randomized traffic.
        do_reset();
        for (int seg_i = 0; seg_i < 300; seg_i++) begin
            k = $urandom_range(0, 9);
            if (k <= 5) s = glyph_tab[$urandom_range(0, 15)];
            else if (k == 6) s = 7'h7F;
            else if (k == 7) s = ($urandom_range(0, 1) == 0) ? 7'h58 : 7'h18;
            else s = 7'($urandom);
            k = $urandom_range(0, 9);
            if (k == 0) d = 4'b0000;
            else if (k == 1) d = 4'b0101;
            else d = 4'(1 << $urandom_range(0, 3));
            k = $urandom_range(1, 8);
            for (int c = 0; c < k; c++) cycle(s, d, ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Receive end of the seven-segment display interface. Samples a multiplexed, active-low 7-segment bus (segments a..g plus a one-hot digit select) and debounces each pattern.
- Decodes each pattern back to a hex nibble and keeps a shadow register per digit.
- Emits a change event over a valid/ready handshake.
- Used for board self-check and loopback verification of the display decoders.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted (2..255).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg_n  input  7  segment bus, active-low; bit0=a … bit6=g
- dig_sel  input  DIGITS  digit select, one-hot, active-high
- out_valid  output  1  event available
- out_ready  input  1  consumer accepts event
- out_digit  output  3  digit index of event
- out_nibble  output  4  decoded value (0 when out_blank or out_err)
- out_blank  output  1  digit went blank (seg_n = 7'h7F)
- out_err  output  1  pattern not a legal glyph
- overflow  output  1  sticky: an event was dropped
- shadow  output  4*DIGITS  current nibble per digit; digit i at bits [4i+3:4i]

Behaviour:
- Reset: all outputs 0; every shadow entry is set to state BLANK; stable counter is 0; input register is 7'h7F with select 0.
- Input stage:
  - {seg_n, dig_sel} is registered each cycle.
  - cnt is 1 on a value change and increments (saturating at STABLE_CYCLES) while the value is unchanged.
- Select check: a select that is not one-hot (zero or multiple bits) forces cnt to 0, and the FSM goes to TRACK. No commit occurs.
- FSM states:
  - TRACK → LOCKED when cnt reaches STABLE_CYCLES. This is the commit, and it happens once per stable run.
  - LOCKED → TRACK on any change of the registered input.
- Commit:
  - Decode the glyph.
  - If the result (value, blank or err) differs from the stored state of the selected digit, update the shadow and push an event.
  - If the result is identical, nothing happens.
- Err results never overwrite the shadow. They always push an event carrying out_err=1 and the last good value in shadow.
- Canonical glyphs, hex of seg_n {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - 7F = blank; any other pattern = err.
- Latency: a pattern present before edge 1 and held stable sets out_valid after edge STABLE_CYCLES+1. The decode stage is registered.
- Output buffer:
  - One entry. Outputs hold stable while out_valid=1 and out_ready=0.
  - Pop occurs when out_valid & out_ready.
  - If a push and a pop happen in the same cycle, the new event is loaded and out_valid stays 1.
  - A push while the buffer is full with no pop drops the new event and sets overflow. Overflow clears only on reset.
- Reset mid-run: a pending event is discarded, the counter and FSM return to their reset state, and no event is produced for the run in progress.

Optional Feature:
- SEG7_READER_ALT_GLYPH_EN
  - Defined: also accept the alternate glyphs 7 = 58 (segment f lit) and 9 = 18 (segment d unlit). These decode to 7 and 9 respectively.
  - Undefined: 58 and 18 decode as err.

Decomposition:
- Package seg7_pkg holds:
  - the 16 canonical glyph constants, the BLANK constant and the alternate glyph constants;
  - the shadow-state encoding: 5 bits, bit4 = blank;
  - the function width constant for the digit index.
- One sub-module, seg7_glyph_decode: combinational, 7 bits in → {nibble, blank, err} out. It honours SEG7_READER_ALT_GLYPH_EN.

Test Plan:
- After reset: hold seg_n=12 with dig_sel=0001 → out_valid rises after edge 5 with digit 0, nibble 5, blank 0, err 0; shadow[3:0]=5.
- Hold 12 for 3 cycles, then 30 for 3 cycles (STABLE_CYCLES=4) → no event, shadow unchanged.
- Present 12 on digit 0, hold 20 cycles, change to 7F, then back to 12 → events in order: 5 (once), blank, 5. No duplicate for the 20-cycle hold.
- seg_n=58 on digit 2, build without the macro → event err=1, shadow[11:8] stays BLANK. Build with the macro → nibble 7.
- Keep out_ready=0 and commit two distinct values → first event held stable, second dropped, overflow=1. Then raise out_ready → one handshake, out_valid falls.
- dig_sel=0011, or assert reset at cnt=3 → no event, no shadow change, all outputs 0 after the reset edge.
